// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM with a shared
// counter, and registered press/release/auto-repeat pulses plus a debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    REL_WAIT
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sync_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             rpt_q;
  logic             ks;

  // Synchronized key level, still active-low (0 = pressed).
  assign ks = sync_q[1];

  // NOTE: all state below is sequential, so every assignment is non-blocking;
  // the pulse outputs default low each cycle and are raised only on an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!ks) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (ks) begin
            state_q <= IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        HELD: begin
          if (ks) begin
            state_q <= REL_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
            rpt_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        REPEAT: begin
          if (ks) begin
            state_q <= REL_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == RPT_LAST) begin
            cnt_q <= '0;
            rpt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        REL_WAIT: begin
          // A bounce back to pressed returns to HELD and restarts the hold timer.
          if (!ks) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign rpt_o     = rpt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: a run-length reference model predicts pulses into a
// scoreboard queue; a negedge monitor pops and compares whatever the DUT emits.
module tb_key_debounce;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;
  logic level_o, press_o, release_o, rpt_o;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n_i  (key_n),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .rpt_o    (rpt_o)
  );

  typedef struct {
    int         cyc;
    logic [2:0] vec;   // {press, release, rpt}
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   obs_p = 0;
  int   obs_r = 0;
  int   obs_t = 0;
  logic exp_level = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: the FSM sees key_n two edges late. A press is a run of
  // D+1 pressed samples while released; a release is a run of D+1 released
  // samples while pressed; repeats fall at anchor+H, then every R cycles.
  initial begin
    logic d1, d2, s;
    bit   pressed;
    int   zrun, orun, anchor, t;
    logic [2:0] v;
    d1 = 1'b1; d2 = 1'b1; pressed = 0; zrun = 0; orun = 0; anchor = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        d1 = 1'b1; d2 = 1'b1; pressed = 0; zrun = 0; orun = 0; anchor = 0;
        exp_level = 1'b0;
        sbq.delete();
      end else begin
        cyc++;
        s  = d2;
        d2 = d1;
        d1 = key_n;
        v  = 3'b000;
        if (!pressed) begin
          if (!s) begin
            zrun++;
            if (zrun == D + 1) begin
              v[2] = 1'b1; pressed = 1; anchor = cyc; zrun = 0; orun = 0;
            end
          end else begin
            zrun = 0;
          end
        end else if (s) begin
          orun++;
          if (orun == D + 1) begin
            v[1] = 1'b1; pressed = 0; orun = 0; zrun = 0;
          end
        end else if (orun > 0) begin
          anchor = cyc;
          orun   = 0;
        end else begin
          t = cyc - anchor;
          if (t == H || (t > H && ((t - H) % R) == 0)) v[0] = 1'b1;
        end
        exp_level = pressed;
        if (v != 3'b000) sbq.push_back('{cyc: cyc, vec: v});
      end
    end
  end

  // Monitor: sampled on the falling edge, away from DUT updates.
  initial begin
    logic [2:0] got;
    exp_t it;
    forever begin
      @(negedge clk);
      check("level", level_o, exp_level);
      got = {press_o, release_o, rpt_o};
      if (got != 3'b000) begin
        if (press_o)   obs_p++;
        if (release_o) obs_r++;
        if (rpt_o)     obs_t++;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          it = sbq.pop_front();
          check("pulse_kind", got, it.vec);
        end else begin
          check("pulse_unexpected", got, 0);
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        it = sbq.pop_front();
        check("pulse_missed", 0, it.vec);
      end
    end
  end

  initial begin
    int p0, r0, t0, len;
    logic lvl;
    rst_n = 1'b1;
    key_n = 1'b1;
    #1 rst_n = 1'b0;

    // Outputs stay low while reset is held, whatever the key does.
    for (int i = 0; i < 8; i++) begin
      step(1);
      key_n = 1'($urandom_range(0, 1));
      check("reset_outputs", {level_o, press_o, release_o, rpt_o}, 0);
    end
    key_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(10);

    // Long press: one press, repeats at +20 and +28, one release.
    p0 = obs_p; r0 = obs_r; t0 = obs_t;
    key_n = 1'b0; step(40);
    key_n = 1'b1; step(15);
    check("long_press_cnt", obs_p - p0, 1);
    check("long_rpt_cnt",   obs_t - t0, 2);
    check("long_rel_cnt",   obs_r - r0, 1);

    // Glitches of 3 and 4 cycles are rejected; 5 cycles is accepted.
    p0 = obs_p; r0 = obs_r; t0 = obs_t;
    key_n = 1'b0; step(3);
    key_n = 1'b1; step(10);
    key_n = 1'b0; step(4);
    key_n = 1'b1; step(10);
    check("glitch_press_cnt", obs_p - p0, 0);
    check("glitch_rel_cnt",   obs_r - r0, 0);
    key_n = 1'b0; step(5);
    key_n = 1'b1; step(12);
    check("min_press_cnt", obs_p - p0, 1);
    check("min_rel_cnt",   obs_r - r0, 1);
    check("min_rpt_cnt",   obs_t - t0, 0);

    // Held 60 cycles past press: five repeats.
    p0 = obs_p; r0 = obs_r; t0 = obs_t;
    key_n = 1'b0; step(64);
    key_n = 1'b1; step(15);
    check("hold60_rpt_cnt", obs_t - t0, 5);
    check("hold60_rel_cnt", obs_r - r0, 1);

    // Release bounce: hold timer restarts, single release at the end.
    p0 = obs_p; r0 = obs_r; t0 = obs_t;
    key_n = 1'b0; step(30);
    key_n = 1'b1; step(2);
    key_n = 1'b0; step(2);
    check("bounce_no_release", obs_r - r0, 0);
    step(23);
    key_n = 1'b1; step(15);
    check("bounce_press_cnt", obs_p - p0, 1);
    check("bounce_rpt_cnt",   obs_t - t0, 2);
    check("bounce_rel_cnt",   obs_r - r0, 1);

    // Reset while repeating: outputs clear at once, no release, fresh press after.
    p0 = obs_p; r0 = obs_r; t0 = obs_t;
    key_n = 1'b0; step(40);
    rst_n = 1'b0;
    #1 check("midreset_outputs", {level_o, press_o, release_o, rpt_o}, 0);
    step(3);
    rst_n = 1'b1;
    check("midreset_no_rel", obs_r - r0, 0);
    step(20);
    check("midreset_repress", obs_p - p0, 2);
    key_n = 1'b1; step(15);
    check("midreset_rel_cnt", obs_r - r0, 1);

    // Randomized segments with occasional resets.
    for (int i = 0; i < 90; i++) begin
      lvl = 1'($urandom_range(0, 1));
      if (lvl) len = $urandom_range(1, 12);
      else if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 6);
      else len = $urandom_range(5, 70);
      key_n = lvl;
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(len);
    end

    key_n = 1'b1;
    step(20);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
